// File: rtl/fft_bitrev_8.sv
`default_nettype none
// ============================================================================
// fft_bitrev_8 : ping-pong reorder buffer, bit-reversed FFT bins -> natural order
// Optional macro FFT_BITREV_IDX_EN adds the dout_idx output.   Rev 1.0
// ============================================================================
module fft_bitrev_8 #(
  parameter int DBW  = 8,
  parameter int CBW  = 3,
  parameter int FILL = 3
) (
  input  logic             clk,
  input  logic             rstx,
  input  logic             clear,
  input  logic             din_vld,
  input  logic [2*DBW-1:0] din,
  output logic             dout_vld,
  output logic             dout_sof,
  output logic [2*DBW-1:0] dout
`ifdef FFT_BITREV_IDX_EN
  ,
  output logic [CBW-1:0]   dout_idx
`endif
);

  localparam int N   = 1 << CBW;
  localparam int SKW = (FILL > 0) ? $clog2(FILL + 1) : 1;
  localparam logic [CBW-1:0] LAST      = CBW'(N - 1);
  localparam logic [SKW-1:0] SKIP_INIT = SKW'(FILL);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] r);
    for (int i = 0; i < CBW; i++) bitrev[i] = r[CBW-1-i];
  endfunction

  logic [2*DBW-1:0] mem_q [2][N];
  logic [2*DBW-1:0] mem_d [2][N];

  logic [SKW-1:0]   skip_q, skip_d;
  logic [CBW-1:0]   wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             rbank_next_q, rbank_next_d;
  logic             pending_q, pending_d;
  logic [0:0]       state_q, state_d;
  logic [CBW-1:0]   rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic [2*DBW-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             dout_sof_q, dout_sof_d;
`ifdef FFT_BITREV_IDX_EN
  logic [CBW-1:0]   dout_idx_q, dout_idx_d;
`endif

  logic wr_en;
  logic frame_done;
  logic take;

  // Write side: skip pipeline-fill samples, then fill the current bank.
  always_comb begin
    skip_d       = skip_q;
    wcnt_d       = wcnt_q;
    wbank_d      = wbank_q;
    rbank_next_d = rbank_next_q;
    wr_en        = 1'b0;
    frame_done   = 1'b0;
    if (clear) begin
      skip_d  = SKIP_INIT;
      wcnt_d  = '0;
      wbank_d = 1'b0;
    end else if (din_vld) begin
      if (skip_q != '0) begin
        skip_d = skip_q - SKW'(1);
      end else begin
        wr_en  = 1'b1;
        wcnt_d = wcnt_q + CBW'(1);
        if (wcnt_q == LAST) begin
          wbank_d      = ~wbank_q;
          rbank_next_d = wbank_q;
          frame_done   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wbank_q][wcnt_q] = din;
  end

  // A completed frame wins over a simultaneous hand-off so it is never lost.
  always_comb begin
    if (clear) pending_d = 1'b0;
    else       pending_d = (pending_q && !take) || frame_done;
  end

  // Read FSM: state register
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Read FSM: next state
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    take    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q) begin
            take    = 1'b1;
            state_d = ST_READ;
            rcnt_d  = '0;
            rbank_d = rbank_next_q;
          end
        end
        ST_READ: begin
          if (rcnt_q == LAST) begin
            rcnt_d = '0;
            if (pending_q) begin
              take    = 1'b1;
              rbank_d = rbank_next_q;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            rcnt_d = rcnt_q + CBW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Read FSM: outputs
  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    dout_sof_d = 1'b0;
`ifdef FFT_BITREV_IDX_EN
    dout_idx_d = dout_idx_q;
`endif
    if (!clear && state_q == ST_READ) begin
      dout_d     = mem_q[rbank_q][bitrev(rcnt_q)];
      dout_vld_d = 1'b1;
      dout_sof_d = (rcnt_q == '0);
`ifdef FFT_BITREV_IDX_EN
      dout_idx_d = rcnt_q;
`endif
    end
  end

  // Buffer contents need no reset: nothing is read before it is rewritten.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      skip_q       <= SKIP_INIT;
      wcnt_q       <= '0;
      wbank_q      <= 1'b0;
      rbank_next_q <= 1'b0;
      pending_q    <= 1'b0;
      rcnt_q       <= '0;
      rbank_q      <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      dout_sof_q   <= 1'b0;
`ifdef FFT_BITREV_IDX_EN
      dout_idx_q   <= '0;
`endif
    end else begin
      skip_q       <= skip_d;
      wcnt_q       <= wcnt_d;
      wbank_q      <= wbank_d;
      rbank_next_q <= rbank_next_d;
      pending_q    <= pending_d;
      rcnt_q       <= rcnt_d;
      rbank_q      <= rbank_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      dout_sof_q   <= dout_sof_d;
`ifdef FFT_BITREV_IDX_EN
      dout_idx_q   <= dout_idx_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_sof = dout_sof_q;
`ifdef FFT_BITREV_IDX_EN
  assign dout_idx = dout_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_8.sv
`default_nettype none
// tb_fft_bitrev_8 : scoreboard bench for fft_bitrev_8, one FILL=0 and one FILL=3 instance.
module tb_fft_bitrev_8;

  logic        clk   = 1'b0;
  logic        rstx  = 1'b0;
  logic        clear = 1'b0;
  logic        vld0  = 1'b0;
  logic        vld3  = 1'b0;
  logic [15:0] din   = '0;

  logic        ov0, os0, ov3, os3;
  logic [15:0] od0, od3;
  logic [2:0]  oi0, oi3;

  always #5 clk = ~clk;

`ifdef FFT_BITREV_IDX_EN
  logic [2:0] di0, di3;
  assign oi0 = di0;
  assign oi3 = di3;
`else
  assign oi0 = 3'd0;
  assign oi3 = 3'd0;
`endif

  fft_bitrev_8 #(.DBW(8), .CBW(3), .FILL(0)) u_dut0 (
    .clk(clk), .rstx(rstx), .clear(clear), .din_vld(vld0), .din(din),
    .dout_vld(ov0), .dout_sof(os0), .dout(od0)
`ifdef FFT_BITREV_IDX_EN
    , .dout_idx(di0)
`endif
  );

  fft_bitrev_8 #(.DBW(8), .CBW(3), .FILL(3)) u_dut3 (
    .clk(clk), .rstx(rstx), .clear(clear), .din_vld(vld3), .din(din),
    .dout_vld(ov3), .dout_sof(os3), .dout(od3)
`ifdef FFT_BITREV_IDX_EN
    , .dout_idx(di3)
`endif
  );

  typedef struct packed {
    int          cyc;
    logic        sof;
    logic [15:0] data;
    logic [2:0]  idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int skip [2];
  int wc   [2];
  logic [2:0] br_tab [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: pops the scoreboard whenever an output is presented or is overdue.
  task automatic mon(input int id, input logic v, input logic s, input logic [15:0] d,
                     input logic [2:0] ix);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (id == 0) begin
      if (q0.size() > 0 && (v || q0[0].cyc <= cyc)) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0 && (v || q1[0].cyc <= cyc)) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (v) begin
      if (!have) begin
        n_tot++;
        $display("FAIL unexpected_out dut%0d: dout_vld=1 dout=%h at cycle %0d, required no output",
                 id, d, cyc);
      end else begin
        check($sformatf("out_cycle dut%0d", id), cyc, e.cyc);
        check($sformatf("dout dut%0d", id), {16'd0, d}, {16'd0, e.data});
        check($sformatf("dout_sof dut%0d", id), {31'd0, s}, {31'd0, e.sof});
`ifdef FFT_BITREV_IDX_EN
        check($sformatf("dout_idx dut%0d", id), {29'd0, ix}, {29'd0, e.idx});
`endif
      end
    end else if (have) begin
      n_tot++;
      $display("FAIL missing_out dut%0d: dout_vld=0 at cycle %0d, required dout=%h", id, cyc, e.data);
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov0, os0, od0, oi0);
    mon(1, ov3, os3, od3, oi3);
  end

  // Drive one cycle of input; the bench model pushes the 8 expected bins
  // (base|0 .. base|7, sof on bin 0) for output at E+2..E+9.
  task automatic send(input int id, input logic v, input logic [15:0] d, input logic [15:0] base);
    exp_t e;
    @(posedge clk); #1;
    clear = 1'b0;
    din   = d;
    vld0  = v && (id == 0);
    vld3  = v && (id == 1);
    if (v) begin
      if (skip[id] > 0) skip[id]--;
      else begin
        wc[id]++;
        if (wc[id] == 8) begin
          wc[id] = 0;
          for (int k = 0; k < 8; k++) begin
            e.cyc  = cyc + 3 + k;
            e.sof  = (k == 0);
            e.data = base | 16'(k);
            e.idx  = 3'(k);
            if (id == 0) q0.push_back(e);
            else         q1.push_back(e);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic send_frame(input int id, input logic [15:0] base, input bit gap);
    for (int i = 0; i < 8; i++) begin
      send(id, 1'b1, base | {13'd0, br_tab[i]}, base);
      if (gap) send(id, 1'b0, 16'hFFFF, 16'h0000);
    end
  endtask

  // Clear with din_vld high on both instances: the sample must be ignored.
  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1; vld0 = 1'b1; vld3 = 1'b1; din = 16'hDEAD;
    while (q0.size() > 0 && q0[$].cyc >= cyc + 1) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].cyc >= cyc + 1) void'(q1.pop_back());
    skip[0] = 0; skip[1] = 3; wc[0] = 0; wc[1] = 0;
    @(posedge clk); #1;
    clear = 1'b0; vld0 = 1'b0; vld3 = 1'b0;
    check("vld_after_clear", {31'd0, ov0}, 32'd0);
    check("sof_after_clear", {31'd0, os0}, 32'd0);
  endtask

  task automatic do_reset_mid();
    @(posedge clk); #3;
    rstx = 1'b0;
    #1;
    check("rst_mid_vld", {31'd0, ov0}, 32'd0);
    check("rst_mid_sof", {31'd0, os0}, 32'd0);
    check("rst_mid_dout", {16'd0, od0}, 32'd0);
`ifdef FFT_BITREV_IDX_EN
    check("rst_mid_idx", {29'd0, oi0}, 32'd0);
`endif
    while (q0.size() > 0 && q0[$].cyc >= cyc) void'(q0.pop_back());
    while (q1.size() > 0 && q1[$].cyc >= cyc) void'(q1.pop_back());
    skip[0] = 0; skip[1] = 3; wc[0] = 0; wc[1] = 0;
    vld0 = 1'b0; vld3 = 1'b0;
    @(negedge clk); #2;
    rstx = 1'b1;
  endtask

  initial begin
    br_tab  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    skip[0] = 0; skip[1] = 3; wc[0] = 0; wc[1] = 0;

    #12;
    check("reset_vld0", {31'd0, ov0}, 32'd0);
    check("reset_sof0", {31'd0, os0}, 32'd0);
    check("reset_dout0", {16'd0, od0}, 32'd0);
    check("reset_vld3", {31'd0, ov3}, 32'd0);
    check("reset_dout3", {16'd0, od3}, 32'd0);
`ifdef FFT_BITREV_IDX_EN
    check("reset_idx0", {29'd0, oi0}, 32'd0);
`endif
    #10 rstx = 1'b1;

    // FILL=0, single frame -> 0x0000..0x0007
    send_frame(0, 16'h0000, 1'b0);
    idle(12);

    // FILL=3: three junk samples discarded, then the frame
    send(1, 1'b1, 16'hAA01, 16'h0000);
    send(1, 1'b1, 16'hAA02, 16'h0000);
    send(1, 1'b1, 16'hAA03, 16'h0000);
    send_frame(1, 16'h0000, 1'b0);
    idle(12);

    // Three back-to-back frames: 24 consecutive outputs
    send_frame(0, 16'h1230, 1'b0);
    send_frame(0, 16'hC3F8, 1'b0);
    send_frame(0, 16'h5A40, 1'b0);
    idle(12);

    // din_vld toggling 1,0,1,0
    send_frame(0, 16'h7F78, 1'b1);
    idle(12);

    // Partial frame dropped by clear, then a full frame; FILL=3 skip reloads
    for (int i = 0; i < 5; i++) send(0, 1'b1, 16'h9990 | {13'd0, br_tab[i]}, 16'h9990);
    do_clear();
    send_frame(0, 16'h4B00, 1'b0);
    idle(12);
    send(1, 1'b1, 16'hAA11, 16'h0000);
    send(1, 1'b1, 16'hAA12, 16'h0000);
    send(1, 1'b1, 16'hAA13, 16'h0000);
    send_frame(1, 16'h6620, 1'b0);
    idle(12);

    // clear while READ is at rcnt=3: bins 0..2 out, then nothing
    send_frame(0, 16'h3C18, 1'b0);
    idle(4);
    do_clear();
    idle(12);

    // rstx pulsed mid-READ, then a clean frame
    send_frame(0, 16'h0E80, 1'b0);
    idle(4);
    do_reset_mid();
    send_frame(0, 16'h2D08, 1'b0);
    idle(14);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_8.md
Name: fft_bitrev_8

Overview:
- Output reorder stage placed directly downstream of the 8-point streaming FFT core (three radix-2 stages).
- The FFT core emits each frame's complex bins in bit-reversed order, packed {im, re}. This block buffers each 8-sample frame in a ping-pong register buffer and re-emits it in natural bin order 0..7.
- Adds frame-start and valid flags for downstream magnitude/detection logic.

Parameters:
- DBW, 8, bit width of each real/imag component (matches the FFT core DBW).
- CBW, 3, index width; frame length is 2**CBW = 8 (only 3 supported).
- FILL, 3, number of valid input samples discarded after reset or clear, to flush the FFT pipeline fill.

Ports:
- clk  input  1  clock.
- rstx  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous restart; same pulse that clears the FFT core counter.
- din_vld  input  1  din carries a valid sample this cycle.
- din  input  2*DBW  FFT output, {im[DBW-1:0], re[DBW-1:0]}, bit-reversed order.
- dout_vld  output  1  dout valid.
- dout_sof  output  1  high with bin 0 of each output frame.
- dout  output  2*DBW  natural-order bin, {im, re}.

Behaviour:
- Reset values (rstx low): dout_vld=0, dout_sof=0, dout=0.
  - Write counter wcnt=0, write bank wbank=0, skip counter = FILL.
  - Read FSM in IDLE, rcnt=0, pending=0.
- Skip phase:
  - While the skip counter is nonzero, each din_vld decrements it and the sample is not written.
  - FILL=0 disables the skip phase.
- Write side:
  - Each accepted din_vld writes din to buf[wbank][wcnt], then wcnt increments.
  - At the write of wcnt=7: wcnt wraps to 0, wbank toggles, pending is set and rbank_next = old wbank.
  - Gaps in din_vld are allowed; wcnt holds during gaps.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when pending=1. On this edge: rbank <= rbank_next, rcnt <= 0, pending cleared.
  - READ: each cycle, dout <= buf[rbank][bitrev(rcnt)] and dout_vld <= 1.
  - READ: dout_sof <= (rcnt==0); rcnt increments.
  - READ -> IDLE after rcnt=7, unless pending is set again that cycle; in that case READ restarts at rcnt=0 on the new bank with no bubble.
  - bitrev(r) = {r[0], r[1], r[2]}.
- Latency, edge E = edge writing the 8th sample of a frame:
  - E+1: FSM enters READ.
  - E+2: dout carries bin 0, with dout_vld=1 and dout_sof=1.
  - E+9: dout carries bin 7.
  - With continuous input, output is continuous, one frame per 8 cycles.
- Overflow is impossible by construction.
  - A frame needs at least 8 input cycles, and READ drains it in exactly 8.
  - The bank being read is never written before its read completes.
  - No backpressure port.
- Outside READ: dout_vld=0 and dout_sof=0; dout holds its last value.
- clear (synchronous, priority over all other activity):
  - wcnt=0, wbank=0, skip counter reloads FILL, pending=0, FSM -> IDLE.
  - dout_vld=0 and dout_sof=0 on the next edge. A partial frame or in-progress output frame is dropped.
  - din is ignored in the clear cycle.
- rstx assertion mid-frame: immediate return to reset values; buffer contents are don't-care and never output before being rewritten.
- Arithmetic: none; data is passed bit-exact.

Optional Feature:
- Macro FFT_BITREV_IDX_EN.
- Defined: adds output port dout_idx [CBW-1:0], registered alongside dout. It equals the natural bin number (rcnt at read), is 0 at reset and holds when dout_vld=0.
- Undefined: port absent, no extra logic.

Test Plan:
- Reset, FILL=0, continuous din_vld; frame din = 0x0000, 0x0004, 0x0002, 0x0006, 0x0001, 0x0005, 0x0003, 0x0007 (bit-reversed bins 0..7) -> dout = 0x0000..0x0007 in order, dout_sof with 0x0000, first output at E+2.
- FILL=3, continuous input 0xAA01, 0xAA02, 0xAA03, then the frame above -> first three samples discarded; output 0x0000..0x0007.
- Three back-to-back frames, continuous din_vld -> 24 consecutive dout_vld cycles, dout_sof every 8th cycle, no bubble.
- din_vld toggled 1,0,1,0 across one frame -> same natural-order output, starting 2 cycles after the 8th accepted sample.
- clear after 5 samples of a frame, then a full new frame -> no output for the partial frame; the new frame is output correctly. clear during READ at rcnt=3 -> dout_vld low next cycle.
- rstx pulsed low mid-READ -> dout_vld=0 and dout=0 immediately; after release with FILL=0 the next full frame is output correctly. With FFT_BITREV_IDX_EN, check dout_idx = 0..7.
